// File: rtl/fifo8k_capture_ctrl_if.sv
// ---------------------------------------------------------------------------
// fifo8k_capture_ctrl_if
//   Bundles the control, FIFO-drive and status signals of the capture
//   sequencer so they travel as one port.
//
//   Driver side (master -> slave):
//     arm, abort, trig, sample_en, cap_len[12:0], rd_req
//   Sequencer side (slave -> master):
//     fifo_rst, fifo_wr_en, fifo_rd_en, bit_valid, busy, done, aborted,
//     state[2:0], wr_count[12:0], rd_count[12:0]
//
//   The sequencer instantiates the slave modport; whatever drives the
//   control inputs and watches status uses the master modport.
// ---------------------------------------------------------------------------
interface fifo8k_capture_ctrl_if;
    logic        arm;
    logic        abort;
    logic        trig;
    logic        sample_en;
    logic [12:0] cap_len;
    logic        rd_req;

    logic        fifo_rst;
    logic        fifo_wr_en;
    logic        fifo_rd_en;
    logic        bit_valid;
    logic        busy;
    logic        done;
    logic        aborted;
    logic [2:0]  state;
    logic [12:0] wr_count;
    logic [12:0] rd_count;

    modport master (
        output arm, abort, trig, sample_en, cap_len, rd_req,
        input  fifo_rst, fifo_wr_en, fifo_rd_en, bit_valid, busy, done,
               aborted, state, wr_count, rd_count
    );

    modport slave (
        input  arm, abort, trig, sample_en, cap_len, rd_req,
        output fifo_rst, fifo_wr_en, fifo_rd_en, bit_valid, busy, done,
               aborted, state, wr_count, rd_count
    );
endinterface

// File: rtl/fifo8k_capture_ctrl.sv
// ---------------------------------------------------------------------------
// fifo8k_capture_ctrl
//   Sequencer for the 1-bit x 8K block-RAM capture FIFO. On arm it clears
//   the FIFO, waits for a trigger, gates a programmed number of qualified
//   samples into the FIFO, drains them under downstream flow control and
//   pulses done. abort cancels any sequence in progress.
//
//   Ports:
//     clk    - single clock; also the FIFO write and read clock
//     rst_n  - asynchronous, active-low reset
//     bus    - fifo8k_capture_ctrl_if.slave (controls in, FIFO drive and
//              status out)
//
//   Parameters:
//     DEPTH      - maximum samples per capture (<= 8191)
//     RST_CYCLES - cycles fifo_rst is held high at the start of each arm
// ---------------------------------------------------------------------------
module fifo8k_capture_ctrl #(
    parameter int DEPTH      = 8191,
    parameter int RST_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    fifo8k_capture_ctrl_if.slave  bus
);

    localparam logic [12:0]      DEPTH_L  = 13'(DEPTH);
    localparam int               CLR_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CLEAR     = 3'd1,
        S_WAIT_TRIG = 3'd2,
        S_CAPTURE   = 3'd3,
        S_DRAIN     = 3'd4,
        S_DONE      = 3'd5
    } state_t;

    state_t           state_reg, state_next;
    logic [12:0]      len_reg;
    logic [12:0]      wr_count_reg;
    logic [12:0]      rd_count_reg;
    logic [CLR_W-1:0] clr_cnt_reg;
    logic             fifo_rst_reg;
    logic             bit_valid_reg;
    logic             aborted_reg;

    logic             wr_en;
    logic             rd_en;
    logic             done_w;
    logic             abort_hit;
    logic [12:0]      len_arm;

    // abort only means something while a sequence is running.
    assign abort_hit = bus.abort && (state_reg != S_IDLE);

    // A zero or oversize request captures the full FIFO.
    assign len_arm = ((bus.cap_len == 13'd0) || (bus.cap_len > DEPTH_L)) ? DEPTH_L : bus.cap_len;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:      if (bus.arm) state_next = S_CLEAR;
            S_CLEAR:     if (clr_cnt_reg == CLR_LAST) state_next = S_WAIT_TRIG;
            S_WAIT_TRIG: if (bus.trig) state_next = S_CAPTURE;
            // Leave on the write/read that reaches len, so no access is
            // ever issued past it.
            S_CAPTURE:   if (wr_en && (wr_count_reg == len_reg - 13'd1)) state_next = S_DRAIN;
            S_DRAIN:     if (rd_en && (rd_count_reg == len_reg - 13'd1)) state_next = S_DONE;
            S_DONE:      state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
        if (abort_hit) begin
            state_next = S_IDLE;
        end
    end

    // ---------------- output logic ----------------
    always_comb begin
        wr_en  = 1'b0;
        rd_en  = 1'b0;
        done_w = 1'b0;
        case (state_reg)
            S_CAPTURE: wr_en  = bus.sample_en && (wr_count_reg < len_reg) && !bus.abort;
            S_DRAIN:   rd_en  = bus.rd_req && (rd_count_reg < len_reg) && !bus.abort;
            S_DONE:    done_w = !bus.abort;
            default: begin
                wr_en  = 1'b0;
                rd_en  = 1'b0;
                done_w = 1'b0;
            end
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_reg       <= DEPTH_L;
            wr_count_reg  <= 13'd0;
            rd_count_reg  <= 13'd0;
            clr_cnt_reg   <= '0;
            fifo_rst_reg  <= 1'b1;
            bit_valid_reg <= 1'b0;
            aborted_reg   <= 1'b0;
        end else begin
            if ((state_reg == S_IDLE) && bus.arm) begin
                len_reg      <= len_arm;
                wr_count_reg <= 13'd0;
                rd_count_reg <= 13'd0;
            end else begin
                if (wr_en) wr_count_reg <= wr_count_reg + 13'd1;
                if (rd_en) rd_count_reg <= rd_count_reg + 13'd1;
            end

            if (state_reg == S_CLEAR) begin
                clr_cnt_reg <= clr_cnt_reg + 1'b1;
            end else begin
                clr_cnt_reg <= '0;
            end

            // Registered from the next state so fifo_rst rises together
            // with entry into CLEAR and covers exactly its cycles.
            fifo_rst_reg  <= (state_next == S_CLEAR);
            bit_valid_reg <= rd_en;
            aborted_reg   <= abort_hit;
        end
    end

    assign bus.fifo_rst   = fifo_rst_reg;
    assign bus.fifo_wr_en = wr_en;
    assign bus.fifo_rd_en = rd_en;
    assign bus.bit_valid  = bit_valid_reg;
    assign bus.busy       = (state_reg != S_IDLE);
    assign bus.done       = done_w;
    assign bus.aborted    = aborted_reg;
    assign bus.state      = state_reg;
    assign bus.wr_count   = wr_count_reg;
    assign bus.rd_count   = rd_count_reg;

endmodule

// File: tb/tb_fifo8k_capture_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fifo8k_capture_ctrl
//   Directed bench for fifo8k_capture_ctrl. Inputs change 1 ns after each
//   rising edge; outputs are observed on the falling edge (per-cycle
//   counters) or a few ns after the rising edge (point checks).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo8k_capture_ctrl;

    logic clk;
    logic rst_n;

    fifo8k_capture_ctrl_if bus ();

    fifo8k_capture_ctrl #(
        .DEPTH      (8191),
        .RST_CYCLES (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert;
    int n_fail;

    // Per-run observation counters.
    int se_mode;   // 0: low, 1: high, 2: every 3rd cycle
    int rd_mode;   // 0: low, 1: high, 3: even cycles
    int idx;
    int c_wr, c_rd, c_bv, c_done, c_done_bv, c_abt, c_rst;
    int wr_first, wr_last, rd_first, rd_last;
    int lag_err, bad_en;
    logic prev_rd;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clr_counts();
        idx = 0;
        c_wr = 0; c_rd = 0; c_bv = 0; c_done = 0; c_done_bv = 0; c_abt = 0; c_rst = 0;
        wr_first = -1; wr_last = -1; rd_first = -1; rd_last = -1;
        lag_err = 0; bad_en = 0;
        prev_rd = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One clock: drive pattern inputs, observe at negedge, advance.
    task automatic cycle();
        case (se_mode)
            1:       bus.sample_en = 1'b1;
            2:       bus.sample_en = ((idx % 3) == 0);
            default: bus.sample_en = 1'b0;
        endcase
        case (rd_mode)
            1:       bus.rd_req = 1'b1;
            3:       bus.rd_req = ((idx % 2) == 0);
            default: bus.rd_req = 1'b0;
        endcase
        @(negedge clk);
        if (bus.fifo_wr_en) begin
            c_wr++;
            if (wr_first < 0) wr_first = idx;
            wr_last = idx;
            if (!bus.sample_en) bad_en++;
        end
        if (bus.fifo_rd_en) begin
            c_rd++;
            if (rd_first < 0) rd_first = idx;
            rd_last = idx;
            if (!bus.rd_req) bad_en++;
        end
        if (bus.bit_valid) c_bv++;
        if (bus.bit_valid !== prev_rd) lag_err++;
        prev_rd = bus.fifo_rd_en;
        if (bus.fifo_rst) c_rst++;
        if (bus.done) begin
            c_done++;
            if (bus.bit_valid) c_done_bv++;
        end
        if (bus.aborted) c_abt++;
        idx++;
        tick();
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic run_until_idle(input string tag, input int budget);
        bit seen_idle;
        seen_idle = 1'b0;
        for (int i = 0; i < budget; i++) begin
            cycle();
            if (bus.state == 3'd0) begin
                seen_idle = 1'b1;
                break;
            end
        end
        check({tag, " reached IDLE"}, 32'(seen_idle), 32'd1);
    endtask

    // Arm with the given length, then ride out CLEAR into WAIT_TRIG.
    task automatic arm_seq(input string tag, input logic [12:0] len);
        se_mode = 0;
        rd_mode = 0;
        bus.cap_len = len;
        bus.arm = 1'b1;
        tick();
        bus.arm = 1'b0;
        check({tag, " state CLEAR"}, 32'(bus.state), 32'd1);
        check({tag, " wr_count cleared"}, 32'(bus.wr_count), 32'd0);
        clr_counts();
        run_n(5);
        check({tag, " fifo_rst cycles"}, c_rst, 32'd4);
        check({tag, " state WAIT_TRIG"}, 32'(bus.state), 32'd2);
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n = 1'b0;
        bus.arm = 1'b0;
        bus.abort = 1'b0;
        bus.trig = 1'b0;
        bus.sample_en = 1'b0;
        bus.cap_len = 13'd0;
        bus.rd_req = 1'b0;
        se_mode = 0;
        rd_mode = 0;
        clr_counts();

        // ---- reset values ----
        repeat (2) @(posedge clk);
        #1;
        check("rst state", 32'(bus.state), 32'd0);
        check("rst fifo_rst", 32'(bus.fifo_rst), 32'd1);
        check("rst wr_count", 32'(bus.wr_count), 32'd0);
        check("rst rd_count", 32'(bus.rd_count), 32'd0);
        check("rst bit_valid", 32'(bus.bit_valid), 32'd0);
        check("rst done", 32'(bus.done), 32'd0);
        check("rst aborted", 32'(bus.aborted), 32'd0);
        check("rst busy", 32'(bus.busy), 32'd0);
        rst_n = 1'b1;
        #1;
        check("release fifo_rst held", 32'(bus.fifo_rst), 32'd1);
        tick();
        check("release fifo_rst low", 32'(bus.fifo_rst), 32'd0);
        $display("txn reset: done");

        // ---- basic capture, len 16 ----
        arm_seq("basic", 13'd16);
        se_mode = 1; rd_mode = 1; bus.trig = 1'b1;
        clr_counts();
        run_until_idle("basic", 100);
        bus.trig = 1'b0;
        check("basic cycles", idx, 32'd34);
        check("basic writes", c_wr, 32'd16);
        check("basic wr_first", wr_first, 32'd1);
        check("basic wr_last", wr_last, 32'd16);
        check("basic reads", c_rd, 32'd16);
        check("basic rd_first", rd_first, 32'd17);
        check("basic rd_last", rd_last, 32'd32);
        check("basic bit_valid", c_bv, 32'd16);
        check("basic lag", lag_err, 32'd0);
        check("basic done", c_done, 32'd1);
        check("basic done with bit_valid", c_done_bv, 32'd1);
        check("basic aborted", c_abt, 32'd0);
        check("basic wr_count", 32'(bus.wr_count), 32'd16);
        check("basic rd_count", 32'(bus.rd_count), 32'd16);
        $display("txn basic: wr=%0d rd=%0d bv=%0d done=%0d", c_wr, c_rd, c_bv, c_done);

        // ---- gated sampling and backpressure, len 8 ----
        arm_seq("gated", 13'd8);
        se_mode = 2; rd_mode = 3; bus.trig = 1'b1;
        clr_counts();
        run_until_idle("gated", 200);
        bus.trig = 1'b0;
        check("gated cycles", idx, 32'd42);
        check("gated writes", c_wr, 32'd8);
        check("gated wr_first", wr_first, 32'd3);
        check("gated wr_last", wr_last, 32'd24);
        check("gated reads", c_rd, 32'd8);
        check("gated rd_first", rd_first, 32'd26);
        check("gated rd_last", rd_last, 32'd40);
        check("gated bit_valid", c_bv, 32'd8);
        check("gated lag", lag_err, 32'd0);
        check("gated qualifiers", bad_en, 32'd0);
        check("gated done", c_done, 32'd1);
        $display("txn gated: wr=%0d rd=%0d bv=%0d done=%0d", c_wr, c_rd, c_bv, c_done);

        // ---- length 1 ----
        arm_seq("len1", 13'd1);
        se_mode = 1; rd_mode = 1; bus.trig = 1'b1;
        clr_counts();
        run_until_idle("len1", 50);
        bus.trig = 1'b0;
        check("len1 cycles", idx, 32'd4);
        check("len1 writes", c_wr, 32'd1);
        check("len1 reads", c_rd, 32'd1);
        check("len1 bit_valid", c_bv, 32'd1);
        check("len1 done", c_done, 32'd1);
        check("len1 wr_count", 32'(bus.wr_count), 32'd1);
        check("len1 rd_count", 32'(bus.rd_count), 32'd1);
        $display("txn len1: wr=%0d rd=%0d done=%0d", c_wr, c_rd, c_done);

        // ---- length 0 means full depth ----
        arm_seq("len0", 13'd0);
        se_mode = 1; rd_mode = 1; bus.trig = 1'b1;
        clr_counts();
        run_until_idle("len0", 20000);
        bus.trig = 1'b0;
        check("len0 cycles", idx, 32'd16384);
        check("len0 writes", c_wr, 32'd8191);
        check("len0 wr_last", wr_last, 32'd8191);
        check("len0 rd_first", rd_first, 32'd8192);
        check("len0 reads", c_rd, 32'd8191);
        check("len0 done", c_done, 32'd1);
        check("len0 wr_count", 32'(bus.wr_count), 32'd8191);
        check("len0 rd_count", 32'(bus.rd_count), 32'd8191);
        $display("txn len0: wr=%0d rd=%0d done=%0d", c_wr, c_rd, c_done);

        // ---- abort mid-capture after 10 writes ----
        arm_seq("abort", 13'd16);
        se_mode = 1; rd_mode = 0; bus.trig = 1'b1;
        clr_counts();
        run_n(11);
        bus.trig = 1'b0;
        check("abort pre wr_count", 32'(bus.wr_count), 32'd10);
        check("abort pre state", 32'(bus.state), 32'd3);
        bus.abort = 1'b1;
        bus.sample_en = 1'b1;
        #1;
        check("abort wr_en forced low", 32'(bus.fifo_wr_en), 32'd0);
        tick();
        bus.abort = 1'b0;
        check("abort state", 32'(bus.state), 32'd0);
        check("abort pulse", 32'(bus.aborted), 32'd1);
        check("abort wr_count frozen", 32'(bus.wr_count), 32'd10);
        check("abort no done", 32'(bus.done), 32'd0);
        tick();
        check("abort pulse ends", 32'(bus.aborted), 32'd0);
        check("abort still idle", 32'(bus.state), 32'd0);
        $display("txn abort: wr_count=%0d", bus.wr_count);

        // ---- re-arm runs CLEAR again ----
        arm_seq("rearm", 13'd16);
        $display("txn rearm: fifo_rst cycles=%0d", c_rst);

        // ---- abort together with arm in WAIT_TRIG ----
        bus.abort = 1'b1;
        bus.arm = 1'b1;
        tick();
        bus.abort = 1'b0;
        bus.arm = 1'b0;
        check("abort+arm state", 32'(bus.state), 32'd0);
        check("abort+arm pulse", 32'(bus.aborted), 32'd1);
        check("abort+arm fifo_rst", 32'(bus.fifo_rst), 32'd0);
        tick();
        check("abort+arm no clear", 32'(bus.state), 32'd0);
        $display("txn abort+arm: state=%0d", bus.state);

        // ---- trig held through CLEAR, arm held through DRAIN ----
        bus.cap_len = 13'd4;
        bus.trig = 1'b1;
        bus.arm = 1'b1;
        tick();
        check("trigclr state CLEAR", 32'(bus.state), 32'd1);
        se_mode = 1; rd_mode = 1;
        clr_counts();
        run_until_idle("trigclr", 100);
        bus.arm = 1'b0;
        bus.trig = 1'b0;
        check("trigclr cycles", idx, 32'd14);
        check("trigclr fifo_rst", c_rst, 32'd4);
        check("trigclr wr_first", wr_first, 32'd5);
        check("trigclr writes", c_wr, 32'd4);
        check("trigclr reads", c_rd, 32'd4);
        check("trigclr done", c_done, 32'd1);
        check("trigclr wr_count", 32'(bus.wr_count), 32'd4);
        $display("txn trigclr: wr_first=%0d wr=%0d rd=%0d", wr_first, c_wr, c_rd);

        // ---- async reset mid-DRAIN ----
        arm_seq("areset", 13'd16);
        se_mode = 1; rd_mode = 1; bus.trig = 1'b1;
        clr_counts();
        run_n(20);
        bus.trig = 1'b0;
        check("areset pre state", 32'(bus.state), 32'd4);
        check("areset pre rd_count", 32'(bus.rd_count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("areset state", 32'(bus.state), 32'd0);
        check("areset fifo_rst", 32'(bus.fifo_rst), 32'd1);
        check("areset wr_en", 32'(bus.fifo_wr_en), 32'd0);
        check("areset rd_en", 32'(bus.fifo_rd_en), 32'd0);
        check("areset wr_count", 32'(bus.wr_count), 32'd0);
        check("areset rd_count", 32'(bus.rd_count), 32'd0);
        check("areset bit_valid", 32'(bus.bit_valid), 32'd0);
        check("areset busy", 32'(bus.busy), 32'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check("areset release fifo_rst", 32'(bus.fifo_rst), 32'd1);
        tick();
        check("areset fifo_rst low", 32'(bus.fifo_rst), 32'd0);
        check("areset idle", 32'(bus.state), 32'd0);
        $display("txn areset: state=%0d fifo_rst=%0d", bus.state, bus.fifo_rst);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo8k_capture_ctrl.md
Name: fifo8k_capture_ctrl

Overview:
- Single-clock sequencer for the 1-bit x 8K block-RAM capture FIFO.
- Clears the FIFO, waits for a trigger, and gates a programmed number of qualified samples into the FIFO.
- Then drains those samples out under downstream flow control and reports completion.
- Sits between the acquisition front end and the serial readout path; drives the FIFO's reset, write-enable and read-enable.

Parameters:
- DEPTH, 8191, maximum samples per capture (FIFO holds at max address; must be <= 8191).
- RST_CYCLES, 4, clk cycles fifo_rst is held high at the start of each arm (>= 1).

Ports:
- clk, input, 1, the block's single clock, also used as both FIFO write and read clocks.
- rst_n, input, 1, reset: asynchronous assert, active-low (the polarity and synchronicity are fixed).
- arm, input, 1, start a capture sequence; honoured only in IDLE.
- abort, input, 1, cancel any sequence in progress.
- trig, input, 1, capture trigger; level-sampled in WAIT_TRIG.
- sample_en, input, 1, qualifies a valid input sample this cycle.
- cap_len, input, 13, requested sample count; 0 means DEPTH; latched on arm.
- rd_req, input, 1, downstream requests one stored bit this cycle.
- fifo_rst, output, 1, FIFO reset, active-high.
- fifo_wr_en, output, 1, FIFO write enable.
- fifo_rd_en, output, 1, FIFO read enable.
- bit_valid, output, 1, FIFO dout holds a requested bit this cycle.
- busy, output, 1, high in every state except IDLE.
- done, output, 1, one-cycle pulse on normal completion.
- aborted, output, 1, one-cycle pulse when abort cancels a sequence.
- state, output, 3, current state encoding: IDLE=0, CLEAR=1, WAIT_TRIG=2, CAPTURE=3, DRAIN=4, DONE=5.
- wr_count, output, 13, samples written in the current capture.
- rd_count, output, 13, samples read in the current drain.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; wr_count, rd_count, bit_valid, done, aborted all 0; fifo_rst=1.
  - First clk edge after release in IDLE drives fifo_rst=0.
- Length latch:
  - On arm in IDLE: len = (cap_len==0 || cap_len>DEPTH) ? DEPTH : cap_len.
  - len is held until the next arm.
- IDLE:
  - All enables low.
  - arm -> CLEAR; wr_count and rd_count cleared on the same edge.
- CLEAR:
  - fifo_rst=1 for exactly RST_CYCLES cycles (registered), then -> WAIT_TRIG.
  - fifo_wr_en and fifo_rd_en are low throughout.
- WAIT_TRIG:
  - trig high at a clk edge -> CAPTURE.
  - The trigger cycle itself writes nothing.
- CAPTURE:
  - fifo_wr_en = sample_en (combinational, state-gated).
  - wr_count increments on each write.
  - The write that makes wr_count==len -> DRAIN on the same edge.
  - No write is ever issued beyond len.
- DRAIN:
  - fifo_rd_en = rd_req && (rd_count < len) (combinational).
  - rd_count increments per read.
  - bit_valid is registered and goes high exactly 1 cycle after each fifo_rd_en.
  - The read that makes rd_count==len -> DONE.
- DONE:
  - done=1 for one cycle, then -> IDLE.
  - bit_valid for the final read is still asserted in this cycle.
- abort (any state except IDLE):
  - Next state is IDLE, with aborted=1 for one cycle.
  - fifo_wr_en and fifo_rd_en are forced low in the abort cycle.
  - Counters freeze at their current values; done is not pulsed.
- Simultaneous events:
  - abort has priority over arm and trig.
  - arm outside IDLE is ignored.
  - abort in IDLE has no effect.
- Reset mid-sequence: immediate return to the reset values above; no partial pulses.
- Counter wrap-around: counters never exceed len and never wrap.
- Outputs in IDLE: wr_count and rd_count retain their last values for inspection until the next arm.

Test Plan:
- Basic capture: reset, arm with cap_len=16, trig after 5 cycles, sample_en constant 1, rd_req constant 1 -> fifo_rst high 4 cycles; 16 consecutive fifo_wr_en; 16 fifo_rd_en; bit_valid 16 cycles lagging rd_en by 1; done pulse; wr_count=rd_count=16.
- Gated sampling and backpressure: cap_len=8, sample_en every 3rd cycle, rd_req alternating 1/0 -> exactly 8 writes spaced 3 cycles apart; reads only on rd_req=1; 8 bit_valid pulses; done once.
- Length edge cases:
  - cap_len=0 -> len=8191; exactly 8191 writes, then DRAIN.
  - cap_len=1 -> single write, single read, done.
- Abort mid-CAPTURE after 10 writes -> aborted pulse; state=IDLE next cycle; wr_count=10; no done.
  - A re-arm then runs CLEAR again with fifo_rst high 4 cycles.
- Simultaneous events:
  - arm asserted during DRAIN is ignored.
  - abort and arm together in WAIT_TRIG -> IDLE with aborted pulse, no CLEAR.
  - trig held high while in CLEAR does not start capture before CLEAR completes.
- Async reset: rst_n low mid-DRAIN, between clk edges -> state=0, fifo_rst=1, all enables and counters 0 immediately; fifo_rst=0 one edge after release.
